ws2812_strip_player: RTL and testbench

WS2812_STRIP_PLAYER -- requirements
Module: ws2812_strip_player

---
 rtl/ws2812_pkg.sv | 32 +++
 rtl/ws2812_pixel_ram.sv | 34 +++
 rtl/ws2812_strip_player.sv | 197 +++++++++++++++++++
 tb/tb_ws2812_strip_player.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 strip player: FSM states, default
// timing constants and the per-channel brightness scaler.
package ws2812_pkg;

  localparam int PIX_W          = 24;
  localparam int DEF_LED_COUNT  = 8;
  localparam int DEF_T0H        = 20;
  localparam int DEF_T1H        = 40;
  localparam int DEF_TBIT       = 63;
  localparam int DEF_TRESET     = 2500;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_BIT_HI = 3'd2,
    ST_BIT_LO = 3'd3,
    ST_LATCH  = 3'd4
  } state_e;

  // c' = (c * (br + 1)) >> 8 ; br=255 is identity, br=0 blanks the channel
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, br} + 16'd1);
    return 8'(prod >> 8);
  endfunction

  // Reorder an {R,G,B} pixel into WS2812 wire order {G,R,B} and scale it
  function automatic logic [23:0] grb_scaled(input logic [23:0] rgb, input logic [7:0] br);
    return {scale_chan(rgb[15:8], br), scale_chan(rgb[23:16], br), scale_chan(rgb[7:0], br)};
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Double-buffered pixel store: one write port, one registered read port.
// Contents are intentionally not reset.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADW   = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADW-1:0]   waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [ADW-1:0]   raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_r [DEPTH];
  logic [PIX_W-1:0] rdata_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Synchronous read port, one cycle latency
  always_ff @(posedge clk) begin
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ws2812_strip_player.sv
// Streams a double-buffered LED frame to a WS2812 strip. Pixels are written
// into the back bank; a commit swaps banks at the next frame boundary.
// Assumes TBIT - T1H >= 3 so the 2-cycle pixel prefetch fits in bit 0's low time.
module ws2812_strip_player
  import ws2812_pkg::*;
#(
  parameter int LED_COUNT = DEF_LED_COUNT,
  parameter int T0H       = DEF_T0H,
  parameter int T1H       = DEF_T1H,
  parameter int TBIT      = DEF_TBIT,
  parameter int TRESET    = DEF_TRESET,
  localparam int AW       = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          commit,
  input  logic [7:0]    brightness,
  output logic          dout,
  output logic          busy,
  output logic          commit_pending,
  output logic          frame_done
);

  localparam int CW = $clog2(((TRESET > TBIT) ? TRESET : TBIT) + 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_T0H_M1    = CW'(T0H - 1);
  localparam logic [CW-1:0] C_T1H_M1    = CW'(T1H - 1);
  localparam logic [CW-1:0] C_TBIT_M1   = CW'(TBIT - 1);
  localparam logic [CW-1:0] C_PREFETCH  = CW'(TBIT - 3);
  localparam logic [CW-1:0] C_TRESET_M1 = CW'(TRESET - 1);
  localparam logic [AW:0]   LED_COUNT_W = (AW + 1)'(LED_COUNT);
  localparam logic [AW-1:0] PIX_LAST    = AW'(LED_COUNT - 1);

  state_e        state_r, state_nxt_s;
  logic [CW-1:0] cyc_r, cyc_nxt_s;
  logic [AW-1:0] pix_r, pix_nxt_s;
  logic [4:0]    bit_r, bit_nxt_s;
  logic [23:0]   sh_r, sh_nxt_s;
  logic [CW-1:0] hi_last_s;
  logic          fd_nxt_s;
  logic          dout_r, busy_r, frame_done_r, pend_r, sel_r;
  logic          ram_we_s;
  logic [AW:0]   ram_waddr_s, ram_raddr_s;
  logic [23:0]   ram_rdata_s;

  // Bank b occupies addresses [b*LED_COUNT, b*LED_COUNT + LED_COUNT).
  // Writes go to the back bank (~sel_r), reads come from the display bank.
  assign ram_we_s    = wr_en && ({1'b0, wr_addr} < LED_COUNT_W);
  assign ram_waddr_s = sel_r ? {1'b0, wr_addr} : ({1'b0, wr_addr} + LED_COUNT_W);
  assign ram_raddr_s = sel_r ? ({1'b0, pix_r} + LED_COUNT_W) : {1'b0, pix_r};
  assign hi_last_s   = sh_r[23] ? C_T1H_M1 : C_T0H_M1;
  assign fd_nxt_s    = (state_nxt_s == ST_LATCH) && (cyc_nxt_s == C_TRESET_M1);

  ws2812_pixel_ram #(
    .DEPTH (2 * LED_COUNT),
    .ADW   (AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (wr_data),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state logic; cyc counts cycles within the current state/bit period
  always_comb begin
    state_nxt_s = state_r;
    cyc_nxt_s   = cyc_r + C_ONE;
    pix_nxt_s   = pix_r;
    bit_nxt_s   = bit_r;
    sh_nxt_s    = sh_r;
    case (state_r)
      ST_IDLE: begin
        cyc_nxt_s = {CW{1'b0}};
        if (enable) begin
          state_nxt_s = ST_LOAD;
          pix_nxt_s   = {AW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // cycle 0 presents the address, cycle 1 sees the registered data
        if (cyc_r == C_ONE) begin
          state_nxt_s = ST_BIT_HI;
          cyc_nxt_s   = {CW{1'b0}};
          bit_nxt_s   = 5'd23;
          sh_nxt_s    = grb_scaled(ram_rdata_s, brightness);
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_BIT_HI: begin
        if (cyc_r == hi_last_s) begin
          state_nxt_s = ST_BIT_LO;
        end else begin
          state_nxt_s = ST_BIT_HI;
        end
      end
      ST_BIT_LO: begin
        // Last bit of a non-final pixel hands its final 2 low cycles to LOAD
        if ((bit_r == 5'd0) && (pix_r != PIX_LAST) && (cyc_r == C_PREFETCH)) begin
          state_nxt_s = ST_LOAD;
          cyc_nxt_s   = {CW{1'b0}};
          pix_nxt_s   = pix_r + AW'(1);
        end else if (cyc_r == C_TBIT_M1) begin
          cyc_nxt_s = {CW{1'b0}};
          if (bit_r == 5'd0) begin
            state_nxt_s = ST_LATCH;
          end else begin
            state_nxt_s = ST_BIT_HI;
            bit_nxt_s   = bit_r - 5'd1;
            sh_nxt_s    = {sh_r[22:0], 1'b0};
          end
        end else begin
          state_nxt_s = ST_BIT_LO;
        end
      end
      ST_LATCH: begin
        if (cyc_r == C_TRESET_M1) begin
          cyc_nxt_s = {CW{1'b0}};
          if (enable) begin
            state_nxt_s = ST_LOAD;
            pix_nxt_s   = {AW{1'b0}};
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_LATCH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cyc_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cyc_r   <= {CW{1'b0}};
      pix_r   <= {AW{1'b0}};
      bit_r   <= 5'd0;
      sh_r    <= 24'd0;
    end else begin
      state_r <= state_nxt_s;
      cyc_r   <= cyc_nxt_s;
      pix_r   <= pix_nxt_s;
      bit_r   <= bit_nxt_s;
      sh_r    <= sh_nxt_s;
    end
  end

  // Registered outputs, computed from next state so they align with state_r
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      dout_r       <= (state_nxt_s == ST_BIT_HI);
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= fd_nxt_s;
    end
  end

  // Bank select and commit handshake; a commit on the swap edge re-arms
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r  <= 1'b0;
      pend_r <= 1'b0;
    end else if (frame_done_r && pend_r) begin
      sel_r  <= ~sel_r;
      pend_r <= commit;
    end else if (!busy_r && pend_r) begin
      sel_r  <= ~sel_r;
      pend_r <= 1'b0;
    end else if (commit) begin
      pend_r <= 1'b1;
    end else begin
      pend_r <= pend_r;
    end
  end

  assign dout           = dout_r;
  assign busy           = busy_r;
  assign frame_done     = frame_done_r;
  assign commit_pending = pend_r;

endmodule

// File: tb/tb_ws2812_strip_player.sv
// Directed/randomized bench: decodes the serial stream back into frames and
// compares them with frames computed from a simple bank/brightness model.
module tb_ws2812_strip_player;

  localparam int LC     = 3;
  localparam int AWT    = 2;
  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int TBIT   = 63;
  localparam int TRESET = 2500;
  localparam int FB     = 9000;

  logic clk = 1'b0;
  logic reset_n, enable, wr_en, commit;
  logic [AWT-1:0] wr_addr;
  logic [23:0] wr_data;
  logic [7:0] brightness;
  logic dout, busy, commit_pending, frame_done;

  always #5 clk = ~clk;

  ws2812_strip_player #(
    .LED_COUNT(LC), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .brightness(brightness), .dout(dout), .busy(busy),
    .commit_pending(commit_pending), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] mem_m [2][LC];
  int sel_m;
  logic [71:0] fq_bits[$];
  int fq_n[$];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame: every pixel of the bank, scaled and sent G,R,B MSB first
  function automatic logic [71:0] exp_frame(input int bank, input int br);
    logic [71:0] v;
    int c, r, g, b;
    v = 72'd0;
    for (int p = 0; p < LC; p++) begin
      c = int'(mem_m[bank][p]);
      r = (c >> 16) & 255;
      g = (c >> 8) & 255;
      b = c & 255;
      v = {v[47:0], 8'((g * (br + 1)) / 256), 8'((r * (br + 1)) / 256), 8'((b * (br + 1)) / 256)};
    end
    return v;
  endfunction

  // Stream decoder: pulse widths, bit periods, latch length, frame capture
  initial begin : monitor
    int cyc, last_rise, nbits, hl;
    logic prev_d;
    logic [71:0] acc;
    cyc = 0; last_rise = 0; nbits = 0; prev_d = 1'b0; acc = 72'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        nbits = 0; acc = 72'd0; prev_d = 1'b0;
      end else begin
        if (dout && !prev_d) begin
          if (nbits > 0) chk("bit_period", 72'(cyc - last_rise), 72'(TBIT));
          last_rise = cyc;
        end
        if (!dout && prev_d) begin
          hl = cyc - last_rise;
          chk("pulse_width", 72'(hl), 72'((hl == T1H) ? T1H : T0H));
          acc = {acc[70:0], (hl == T1H)};
          nbits++;
        end
        if (frame_done) begin
          chk("latch_len", 72'(cyc - last_rise), 72'(TBIT + TRESET - 1));
          fq_bits.push_back(acc);
          fq_n.push_back(nbits);
          nbits = 0; acc = 72'd0;
        end
        prev_d = dout;
      end
    end
  end

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = AWT'(a); wr_data = d;
    if (a < LC) mem_m[1 - sel_m][a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done_seen", 72'(frame_done), 72'(1));
  endtask

  task automatic pop(input string tag, input int bank, input int br);
    logic [71:0] e;
    e = exp_frame(bank, br);
    chk({tag, "_avail"}, 72'(fq_n.size() > 0), 72'(1));
    if (fq_n.size() > 0) begin
      chk({tag, "_nbits"}, 72'(fq_n.pop_front()), 72'(72));
      chk(tag, fq_bits.pop_front(), e);
    end
  endtask

  initial begin : watchdog
    #(10 * 95000);
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not complete");
  end

  initial begin : stimulus
    int b3, k;
    logic [23:0] swap_px;
    reset_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 24'd0;
    commit = 1'b0; brightness = 8'd255; sel_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 72'(dout), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
    chk("rst_pending", 72'(commit_pending), 72'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Fill bank 1 and swap it in while idle
    wr(0, 24'hFF0000);
    wr(1, 24'h0000FF);
    wr(2, 24'($urandom));
    commit_pulse();
    chk("idle_pending_set", 72'(commit_pending), 72'(1));
    @(negedge clk);
    chk("idle_swap_done", 72'(commit_pending), 72'(0));
    sel_m = 1;
    wr(3, 24'hDEADBE);   // out of range: must not touch anything

    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_streaming", 72'(busy), 72'(1));
    wait_fd(FB);
    brightness = 8'd0;
    @(negedge clk);
    pop("frame1", 1, 255);

    wait_fd(FB);
    b3 = int'($urandom_range(1, 254));
    brightness = 8'(b3);
    @(negedge clk);
    pop("frame2_dark", 1, 0);

    // Mid-frame: fill bank 0, commit twice, swap only at the boundary
    repeat (1500) @(negedge clk);
    wr(0, 24'hFFFFFF);
    wr(1, 24'($urandom));
    wr(2, 24'($urandom));
    commit_pulse();
    chk("mid_pending", 72'(commit_pending), 72'(1));
    repeat (500) @(negedge clk);
    commit_pulse();
    chk("mid_pending_again", 72'(commit_pending), 72'(1));
    wait_fd(FB);
    // Commit and write landing on the swap edge itself
    swap_px = 24'($urandom);
    commit = 1'b1; brightness = 8'd127;
    wr_en = 1'b1; wr_addr = AWT'(2); wr_data = swap_px;
    mem_m[1 - sel_m][2] = swap_px;
    @(negedge clk);
    commit = 1'b0; wr_en = 1'b0;
    chk("rearm_pending", 72'(commit_pending), 72'(1));
    sel_m = 0;
    pop("frame3_old", 1, b3);

    wait_fd(FB);
    brightness = 8'd255;
    @(negedge clk);
    chk("pending_cleared", 72'(commit_pending), 72'(0));
    sel_m = 1;
    pop("frame4_half", 0, 127);

    // Drop enable mid-frame: frame must finish, then idle
    repeat (2000) @(negedge clk);
    enable = 1'b0;
    wait_fd(FB);
    @(negedge clk);
    pop("frame5_stop", 1, 255);
    repeat (3) @(negedge clk);
    chk("idle_busy", 72'(busy), 72'(0));
    chk("idle_dout", 72'(dout), 72'(0));
    repeat (100) @(negedge clk);
    chk("no_extra_frame", 72'(fq_n.size()), 72'(0));

    // Reset in the middle of a high pulse
    enable = 1'b1;
    repeat (10) @(negedge clk);
    commit_pulse();
    chk("busy_pending", 72'(commit_pending), 72'(1));
    k = 0;
    while (dout !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("dout_high_pre_reset", 72'(dout), 72'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", 72'(dout), 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    chk("mid_rst_pending", 72'(commit_pending), 72'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sel_m = 0;
    wait_fd(FB);
    @(negedge clk);
    pop("frame6_bank0", 0, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
